// File: rtl/axil_mem_slave_if.sv
// AXI4-Lite bus bundle between an M_AXI master and axil_mem_slave.
// Bus widths come from the shared AXI_* macros; defaults are supplied when the SoC has not set them.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_STROBE_WIDTH
`define AXI_STROBE_WIDTH 4
`endif
`ifndef AXI_PROT_WIDTH
`define AXI_PROT_WIDTH 3
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif

interface axil_mem_slave_if;
  logic                          awvalid;
  logic                          awready;
  logic [`AXI_ADDR_WIDTH-1:0]    awaddr;
  logic [`AXI_PROT_WIDTH-1:0]    awprot;
  logic                          wvalid;
  logic                          wready;
  logic [`AXI_DATA_WIDTH-1:0]    wdata;
  logic [`AXI_STROBE_WIDTH-1:0]  wstrb;
  logic                          bvalid;
  logic                          bready;
  logic [`AXI_RESP_WIDTH-1:0]    bresp;
  logic                          arvalid;
  logic                          arready;
  logic [`AXI_ADDR_WIDTH-1:0]    araddr;
  logic [`AXI_PROT_WIDTH-1:0]    arprot;
  logic                          rvalid;
  logic                          rready;
  logic [`AXI_DATA_WIDTH-1:0]    rdata;
  logic [`AXI_RESP_WIDTH-1:0]    rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_mem_slave.sv
// AXI4-Lite memory responder: word-addressed RAM with byte strobes, one write and one read in flight.
// Define AXIL_MEM_RANGE_CHECK_EN to answer out-of-window accesses with SLVERR instead of aliasing.
module axil_mem_slave #(
  parameter int unsigned                DEPTH_WORDS = 1024,
  parameter logic [`AXI_ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic            CLK,
  input  logic            RST,
  axil_mem_slave_if.slave s_axi
);
  localparam int unsigned ADDR_W = `AXI_ADDR_WIDTH;
  localparam int unsigned DATA_W = `AXI_DATA_WIDTH;
  localparam int unsigned STRB_W = `AXI_STROBE_WIDTH;
  localparam int unsigned RESP_W = `AXI_RESP_WIDTH;
  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);

  localparam logic [RESP_W-1:0] RESP_OKAY   = RESP_W'(0);
  localparam logic [RESP_W-1:0] RESP_SLVERR = RESP_W'(2);

  // Word index inside the window; the byte offset bits and any bits above the RAM are dropped.
  function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_W-1:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 2);
  endfunction

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_word,
                                                    input logic [DATA_W-1:0] new_word,
                                                    input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int b = 0; b < int'(STRB_W); b++) begin
      if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic                aw_full;
  logic                w_full;
  logic [ADDR_W-1:0]   aw_addr_p0;
  logic [DATA_W-1:0]   w_data_p0;
  logic [STRB_W-1:0]   w_strb_p0;
  logic                bvalid;
  logic [RESP_W-1:0]   bresp;
  logic                rd_pend;
  logic [DATA_W-1:0]   rdata;
  logic [RESP_W-1:0]   rresp;

  logic                aw_hs;
  logic                w_hs;
  logic                ar_hs;
  logic                b_hs;
  logic                r_hs;
  logic                commit;
  logic                wr_ok;
  logic                rd_ok;
  logic [IDX_W-1:0]    wr_idx;
  logic [IDX_W-1:0]    rd_idx;
  logic [DATA_W-1:0]   rd_word;

  logic                aw_full_nxt;
  logic                w_full_nxt;
  logic                bvalid_nxt;
  logic [RESP_W-1:0]   bresp_nxt;
  logic                rd_pend_nxt;
  logic [DATA_W-1:0]   rdata_nxt;
  logic [RESP_W-1:0]   rresp_nxt;

  logic                unused_prot;
  assign unused_prot = ^{s_axi.awprot, s_axi.arprot};

`ifdef AXIL_MEM_RANGE_CHECK_EN
  // Offset above the window (or a wrapped offset below BASE_ADDR) sets a bit above the RAM index.
  function automatic logic in_window(input logic [ADDR_W-1:0] addr);
    return ((addr - BASE_ADDR) >> (IDX_W + 2)) == '0;
  endfunction

  assign wr_ok = in_window(aw_addr_p0);
  assign rd_ok = in_window(s_axi.araddr);
`else
  assign wr_ok = 1'b1;
  assign rd_ok = 1'b1;
`endif

  // READYs depend only on registered state and RST, never on the master's VALIDs.
  assign s_axi.awready = ~aw_full & ~RST;
  assign s_axi.wready  = ~w_full  & ~RST;
  assign s_axi.arready = ~rd_pend & ~RST;
  assign s_axi.bvalid  = bvalid;
  assign s_axi.bresp   = bresp;
  assign s_axi.rvalid  = rd_pend;
  assign s_axi.rdata   = rdata;
  assign s_axi.rresp   = rresp;

  assign aw_hs  = s_axi.awvalid & s_axi.awready;
  assign w_hs   = s_axi.wvalid  & s_axi.wready;
  assign ar_hs  = s_axi.arvalid & s_axi.arready;
  assign b_hs   = bvalid  & s_axi.bready;
  assign r_hs   = rd_pend & s_axi.rready;
  assign commit = aw_full & w_full & ~bvalid;

  assign wr_idx  = word_index(aw_addr_p0);
  assign rd_idx  = word_index(s_axi.araddr);
  assign rd_word = rd_ok ? mem[rd_idx] : '0;

  always_comb begin
    aw_full_nxt = aw_full;
    w_full_nxt  = w_full;
    bvalid_nxt  = bvalid;
    bresp_nxt   = bresp;
    rd_pend_nxt = rd_pend;
    rdata_nxt   = rdata;
    rresp_nxt   = rresp;

    if (commit) begin
      aw_full_nxt = 1'b0;
      w_full_nxt  = 1'b0;
      bvalid_nxt  = 1'b1;
      bresp_nxt   = wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs) aw_full_nxt = 1'b1;
      if (w_hs)  w_full_nxt  = 1'b1;
      if (b_hs)  bvalid_nxt  = 1'b0;
    end

    // R payload is only reloaded on an AR handshake, so it stays stable while RVALID waits.
    if (ar_hs) begin
      rd_pend_nxt = 1'b1;
      rdata_nxt   = rd_word;
      rresp_nxt   = rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (r_hs) begin
      rd_pend_nxt = 1'b0;
    end
  end

  // p0: control and response state
  always_ff @(posedge CLK) begin
    if (RST) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      rd_pend <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
    end else begin
      aw_full <= aw_full_nxt;
      w_full  <= w_full_nxt;
      bvalid  <= bvalid_nxt;
      bresp   <= bresp_nxt;
      rd_pend <= rd_pend_nxt;
      rdata   <= rdata_nxt;
      rresp   <= rresp_nxt;
    end
  end

  // p0: latched write address and data, qualified by aw_full / w_full
  always_ff @(posedge CLK) begin
    if (aw_hs) aw_addr_p0 <= s_axi.awaddr;
    if (w_hs) begin
      w_data_p0 <= s_axi.wdata;
      w_strb_p0 <= s_axi.wstrb;
    end
  end

  // RAM commit; a read of the same word on this edge sees the pre-write contents.
  always_ff @(posedge CLK) begin
    if (!RST && commit && wr_ok) mem[wr_idx] <= merge_bytes(mem[wr_idx], w_data_p0, w_strb_p0);
  end
endmodule
